arcade_input_mapper: RTL and testbench

Parametrised successor to the per-core PS/2 and joystick button decode. It merges the PS/2 keyboard and up to NPLAYERS MiSTer joystick words into registered per-player direction, button and start signals. It adds four-way screen-rotation remapping, a frame-timed coin pulse generator and per-button autofire. It sits between hps_io and the arcade core's button inputs.

---
 rtl/arcade_input_pkg.sv | 40 ++++
 rtl/arcade_input_mapper_coin.sv | 67 ++++++
 rtl/arcade_input_mapper.sv | 175 +++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// Shared key codes, joystick bit layout and enums for the arcade input mapper.
package arcade_input_pkg;

  // Key codes are {extended, scancode}
  localparam logic [8:0] KEY_UP     = 9'h175;
  localparam logic [8:0] KEY_DOWN   = 9'h172;
  localparam logic [8:0] KEY_LEFT   = 9'h16B;
  localparam logic [8:0] KEY_RIGHT  = 9'h174;
  localparam logic [8:0] KEY_BTN0   = 9'h014;
  localparam logic [8:0] KEY_BTN1   = 9'h011;
  localparam logic [8:0] KEY_BTN2   = 9'h029;
  localparam logic [8:0] KEY_START1 = 9'h005;
  localparam logic [8:0] KEY_START2 = 9'h006;
  localparam logic [8:0] KEY_COIN   = 9'h02E;

  localparam int K_UP     = 0;
  localparam int K_DOWN   = 1;
  localparam int K_LEFT   = 2;
  localparam int K_RIGHT  = 3;
  localparam int K_BTN0   = 4;
  localparam int K_BTN1   = 5;
  localparam int K_BTN2   = 6;
  localparam int K_START1 = 7;
  localparam int K_START2 = 8;
  localparam int K_COIN   = 9;
  localparam int NKEYS    = 10;

  typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rot_e;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} coin_state_e;

  function automatic int joy_start_bit(input int nbuttons);
    return 4 + nbuttons;
  endfunction

  function automatic int joy_coin_bit(input int nbuttons);
    return 5 + nbuttons;
  endfunction

endpackage

// File: rtl/arcade_input_mapper_coin.sv
// Coin pulse stretcher: COIN_FRAMES frames high, one frame gap, one-deep trigger queue.
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int COIN_FRAMES = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic trig,
  input  logic frame_tick,
  output logic coin
);

  localparam int CNT_W = $clog2(COIN_FRAMES + 1);

  coin_state_e      state;
  logic [CNT_W-1:0] count;
  logic             pending;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      pending <= 1'b0;
      coin    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            state <= ACTIVE;
            coin  <= 1'b1;
            count <= CNT_W'(COIN_FRAMES);
          end
        end
        ACTIVE: begin
          if (trig) pending <= 1'b1;
          if (frame_tick) begin
            if (count <= CNT_W'(1)) begin
              state <= GAP;
              coin  <= 1'b0;
              count <= '0;
            end else begin
              count <= count - CNT_W'(1);
            end
          end
        end
        GAP: begin
          // A trigger landing on the gap-closing frame is served immediately
          if (frame_tick) begin
            if (pending || trig) begin
              state   <= ACTIVE;
              coin    <= 1'b1;
              count   <= CNT_W'(COIN_FRAMES);
              pending <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (trig) begin
            pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keyboard and MiSTer joysticks into registered per-player controls,
// with screen-rotation remap, autofire and a frame-timed coin pulse.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NPLAYERS      = 2,
  parameter int NBUTTONS      = 3,
  parameter int COIN_FRAMES   = 4,
  parameter int COIN_ON_START = 1,
  parameter int AF_FRAMES     = 3
) (
  input  logic                         clk_sys,
  input  logic                         reset_n,
  input  logic [64:0]                  ps2_key,
  input  logic [16*NPLAYERS-1:0]       joystick,
  input  logic [1:0]                   rotate,
  input  logic [NBUTTONS-1:0]          autofire_en,
  input  logic                         frame_tick,
  output logic [4*NPLAYERS-1:0]        dir,
  output logic [NBUTTONS*NPLAYERS-1:0] btn,
  output logic [NPLAYERS-1:0]          start,
  output logic                         coin
);

  localparam int START_BIT = joy_start_bit(NBUTTONS);
  localparam int COIN_BIT  = joy_coin_bit(NBUTTONS);
  localparam int NKB       = (NBUTTONS < 3) ? NBUTTONS : 3;
  localparam int NKS       = (NPLAYERS < 2) ? NPLAYERS : 2;
  localparam int AF_W      = $clog2(AF_FRAMES + 1);

  // {up, down, left, right}
  function automatic logic [3:0] rotate_dir(input logic [3:0] d, input rot_e r);
    logic [3:0] o;
    case (r)
      ROT_90:  o = {d[1], d[0], d[2], d[3]};
      ROT_180: o = {d[2], d[3], d[0], d[1]};
      ROT_270: o = {d[0], d[1], d[3], d[2]};
      default: o = d;
    endcase
    return o;
  endfunction

  logic             primed_p0;
  logic             toggle_p0;
  logic [NKEYS-1:0] key_p0;
  logic             ps2_pressed;
  logic             ps2_ext;
  logic [8:0]       ps2_code;
  logic             ps2_event;

  assign ps2_pressed = ps2_key[15:8] != 8'hF0;
  assign ps2_ext     = ps2_pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
  assign ps2_code    = (ps2_key[63:24] != '0) ? 9'd0 : {ps2_ext, ps2_key[7:0]};
  assign ps2_event   = primed_p0 && (ps2_key[64] != toggle_p0);

  // Stage p0: key state, first cycle after reset only primes the toggle bit
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      primed_p0 <= 1'b0;
      toggle_p0 <= 1'b0;
      key_p0    <= '0;
    end else begin
      primed_p0 <= 1'b1;
      toggle_p0 <= ps2_key[64];
      if (ps2_event) begin
        case (ps2_code)
          KEY_UP:     key_p0[K_UP]     <= ps2_pressed;
          KEY_DOWN:   key_p0[K_DOWN]   <= ps2_pressed;
          KEY_LEFT:   key_p0[K_LEFT]   <= ps2_pressed;
          KEY_RIGHT:  key_p0[K_RIGHT]  <= ps2_pressed;
          KEY_BTN0:   key_p0[K_BTN0]   <= ps2_pressed;
          KEY_BTN1:   key_p0[K_BTN1]   <= ps2_pressed;
          KEY_BTN2:   key_p0[K_BTN2]   <= ps2_pressed;
          KEY_START1: key_p0[K_START1] <= ps2_pressed;
          KEY_START2: key_p0[K_START2] <= ps2_pressed;
          KEY_COIN:   key_p0[K_COIN]   <= ps2_pressed;
          default: ;
        endcase
      end
    end
  end

  logic [NPLAYERS-1:0][3:0]          dir_raw;
  logic [NPLAYERS-1:0][NBUTTONS-1:0] btn_raw;
  logic [NPLAYERS-1:0]               start_raw;
  logic                              coin_raw;
  logic [2:0]                        key_btn;
  logic [1:0]                        key_st;
  logic [NBUTTONS-1:0]               key_btn_w;
  logic [NPLAYERS-1:0]               key_start_w;

  always_comb begin
    key_btn     = {key_p0[K_BTN2], key_p0[K_BTN1], key_p0[K_BTN0]};
    key_st      = {key_p0[K_START2], key_p0[K_START1]};
    key_btn_w   = '0;
    key_btn_w[NKB-1:0] = key_btn[NKB-1:0];
    key_start_w = '0;
    key_start_w[NKS-1:0] = key_st[NKS-1:0];
    coin_raw    = key_p0[K_COIN];
    for (int p = 0; p < NPLAYERS; p++) begin
      dir_raw[p]   = joystick[16*p +: 4];
      btn_raw[p]   = joystick[16*p+4 +: NBUTTONS];
      start_raw[p] = joystick[16*p+START_BIT];
      coin_raw     = coin_raw | joystick[16*p+COIN_BIT];
    end
    dir_raw[0] = dir_raw[0] | {key_p0[K_UP], key_p0[K_DOWN], key_p0[K_LEFT], key_p0[K_RIGHT]};
    btn_raw[0] = btn_raw[0] | key_btn_w;
    start_raw  = start_raw | key_start_w;
  end

  logic            af_phase;
  logic [AF_W-1:0] af_cnt;
  logic [NBUTTONS-1:0] af_mask;

  assign af_mask = ~autofire_en | {NBUTTONS{af_phase}};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
    end else if (frame_tick) begin
      if (af_cnt == AF_W'(AF_FRAMES - 1)) begin
        af_cnt   <= '0;
        af_phase <= ~af_phase;
      end else begin
        af_cnt <= af_cnt + AF_W'(1);
      end
    end
  end

  logic                coin_prev_p0;
  logic [NPLAYERS-1:0] start_prev_p0;
  logic                trig_p0;
  logic                start_trig;

  assign start_trig = (COIN_ON_START != 0) ? |(start_raw & ~start_prev_p0) : 1'b0;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      coin_prev_p0  <= 1'b0;
      start_prev_p0 <= '0;
      trig_p0       <= 1'b0;
    end else begin
      coin_prev_p0  <= coin_raw;
      start_prev_p0 <= start_raw;
      trig_p0       <= (coin_raw & ~coin_prev_p0) | start_trig;
    end
  end

  // Stage p1: registered player outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dir   <= '0;
      btn   <= '0;
      start <= '0;
    end else begin
      for (int p = 0; p < NPLAYERS; p++) begin
        dir[4*p +: 4]               <= rotate_dir(dir_raw[p], rot_e'(rotate));
        btn[NBUTTONS*p +: NBUTTONS] <= btn_raw[p] & af_mask;
      end
      start <= start_raw;
    end
  end

  coin_pulser #(
    .COIN_FRAMES(COIN_FRAMES)
  ) u_coin (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .trig       (trig_p0),
    .frame_tick (frame_tick),
    .coin       (coin)
  );

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboard bench for arcade_input_mapper: 4 players, 3 buttons, 4-frame coin, 3-frame autofire.
module tb_arcade_input_mapper;

  localparam int NP = 4;
  localparam int NB = 3;
  localparam logic [63:0] JOY_COIN  = 64'h1 << 8;
  localparam logic [63:0] JOY_ST3   = 64'h1 << 55;

  logic                 clk_sys = 1'b0;
  logic                 reset_n;
  logic [64:0]          ps2_key;
  logic [16*NP-1:0]     joystick;
  logic [1:0]           rotate;
  logic [NB-1:0]        autofire_en;
  logic                 frame_tick;
  logic [4*NP-1:0]      dir;
  logic [NB*NP-1:0]     btn;
  logic [NP-1:0]        start;
  logic                 coin;

  arcade_input_mapper #(
    .NPLAYERS(NP), .NBUTTONS(NB), .COIN_FRAMES(4), .COIN_ON_START(1), .AF_FRAMES(3)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
    .rotate(rotate), .autofire_en(autofire_en), .frame_tick(frame_tick),
    .dir(dir), .btn(btn), .start(start), .coin(coin)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;

  typedef struct {
    int          due;
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0:       return 32'(dir);
      1:       return 32'(btn);
      2:       return 32'(start);
      default: return 32'(coin);
    endcase
  endfunction

  // sel: 0 dir, 1 btn, 2 start, 3 coin; lat = cycles from now
  task automatic expect_out(input string tag, input int sel, input logic [31:0] exp, input int lat);
    sb_t e;
    e.due = cyc + lat;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  always @(negedge clk_sys) begin
    sb_t e;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      check(e.tag, pick(e.sel), e.exp);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic ps2_ev(input logic [63:0] w);
    ps2_key = {~ps2_key[64], w};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b0;
    ps2_key     = {1'b1, 64'hE075};
    joystick    = '0;
    rotate      = 2'd0;
    autofire_en = '0;
    frame_tick  = 1'b0;
    tick(3);
    check("rst_dir", 32'(dir), 0);
    check("rst_btn", 32'(btn), 0);
    check("rst_start", 32'(start), 0);
    check("rst_coin", 32'(coin), 0);

    // Release with a stale toggle bit: must only prime
    reset_n = 1'b1;
    expect_out("prime_dir1", 0, 0, 1);
    expect_out("prime_dir2", 0, 0, 2);
    expect_out("prime_dir3", 0, 0, 3);
    tick(4);

    // Keyboard decode
    ps2_ev(64'hE075);
    expect_out("kb_up_lat", 0, 0, 1);
    expect_out("kb_up", 0, 32'h8, 2);
    tick(2);
    ps2_ev(64'hE0F075);
    expect_out("kb_up_held", 0, 32'h8, 1);
    expect_out("kb_up_rel", 0, 0, 2);
    tick(2);
    ps2_ev(64'h75);
    expect_out("kb_kp8", 0, 0, 2);
    tick(2);
    ps2_ev(64'hF075);
    tick(2);
    ps2_ev(64'h0000_0001_0000_0014);
    expect_out("kb_junk", 1, 0, 2);
    tick(2);
    ps2_ev(64'h14);
    expect_out("kb_ctrl", 1, 32'h1, 2);
    tick(2);
    ps2_ev(64'h11);
    expect_out("kb_alt", 1, 32'h3, 2);
    tick(2);
    ps2_ev(64'hF014);
    expect_out("kb_ctrl_rel", 1, 32'h2, 2);
    tick(2);
    ps2_ev(64'hF011);
    expect_out("kb_alt_rel", 1, 0, 2);
    tick(2);
    ps2_ev(64'hE06B);
    joystick = 64'h1;
    expect_out("kb_joy_or", 0, 32'h3, 2);
    tick(2);
    ps2_ev(64'hE0F06B);
    joystick = '0;
    expect_out("kb_joy_clr", 0, 0, 2);
    tick(2);

    // Rotation
    joystick = 64'h2; rotate = 2'd1;
    expect_out("rot90_left", 0, 32'h8, 1);
    tick(1);
    rotate = 2'd3;
    expect_out("rot270_left", 0, 32'h4, 1);
    tick(1);
    joystick = 64'h4;
    expect_out("rot270_down", 0, 32'h1, 1);
    tick(1);
    joystick = 64'h8; rotate = 2'd2;
    expect_out("rot180_up", 0, 32'h4, 1);
    tick(1);
    joystick = 64'h1 << 35; rotate = 2'd1;
    expect_out("rot90_p2_up", 0, 32'h0100, 1);
    tick(1);
    joystick = '0; rotate = 2'd0;
    expect_out("rot_clr", 0, 0, 1);
    tick(2);

    // Coin: trigger coinciding with a frame tick does not consume a frame
    for (int i = 0; i < 25; i++) begin
      joystick   = (i == 0) ? JOY_COIN : '0;
      frame_tick = (i % 4 == 1);
      expect_out("coin_a", 3, 32'((i >= 2) && (i <= 17)), 0);
      tick(1);
    end
    frame_tick = 1'b0;
    tick(2);

    // Coin: one retrigger queued behind a gap, third dropped
    for (int i = 0; i < 48; i++) begin
      joystick   = (i == 0 || i == 5 || i == 9) ? JOY_COIN : '0;
      frame_tick = (i % 4 == 3);
      expect_out("coin_b", 3, 32'(((i >= 2) && (i <= 15)) || ((i >= 20) && (i <= 35))), 0);
      tick(1);
    end
    frame_tick = 1'b0;
    tick(2);

    // Starts from keyboard and joystick together raise one coin
    ps2_ev(64'h06);
    expect_out("start_kb_lat", 2, 0, 1);
    tick(1);
    joystick = JOY_ST3;
    expect_out("start_mix", 2, 32'hA, 1);
    expect_out("coin_st_lat", 3, 0, 1);
    tick(1);
    expect_out("coin_st_rise", 3, 1, 1);
    tick(1);
    for (int j = 0; j < 24; j++) begin
      frame_tick = (j % 4 == 0);
      expect_out("coin_st", 3, 32'(j <= 12), 0);
      tick(1);
    end
    frame_tick = 1'b0;
    joystick = '0;
    ps2_ev(64'hF006);
    expect_out("start_rel", 2, 0, 2);
    tick(3);

    // Asynchronous reset during a coin pulse
    joystick = JOY_COIN;
    tick(1);
    joystick = '0;
    tick(2);
    check("coin_pre_rst", 32'(coin), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("coin_async_rst", 32'(coin), 0);
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // Autofire on button 0 only
    autofire_en = 3'b001;
    for (int i = 0; i < 31; i++) begin
      joystick   = 64'h30;
      frame_tick = (i % 2 == 1);
      if (i >= 1) expect_out("af_btn", 1, 32'h2 | 32'((((i - 1) / 6) % 2) == 0), 0);
      tick(1);
    end
    joystick    = '0;
    frame_tick  = 1'b0;
    autofire_en = '0;

    for (int k = 0; k < 20 && sbq.size() > 0; k++) tick(1);
    check("sb_drain", 32'(sbq.size()), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
